// File: rtl/fwd_register_slice.sv
// Two-entry elastic register slice for valid/ready streams: out_valid, out_data,
// in_ready and occupancy all come straight from flops, so no combinational path crosses it.
module fwd_register_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  // Handshake: a beat moves on a rising edge where valid && ready are both 1.
  // The producer holds valid/data until that edge; ready never depends on valid.
  // Here push = in_valid && in_ready, pop = out_valid && out_ready.

  // State encoding equals the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  in_ready_q;
  logic                  in_ready_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  push;
  logic                  pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          main_d = in_data;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain case exists.
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Output flags are decoded from the next state and registered alongside it.
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    occ_d       = state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_fwd_register_slice.sv
// Directed vector table plus reset and randomized scoreboard sequences for fwd_register_slice.
module tb_fwd_register_slice;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  fwd_register_slice #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_ir, input logic e_ov,
                            input logic [W-1:0] e_od, input logic [1:0] e_occ);
    check({tag, ".in_ready"}, W'(in_ready), W'(e_ir));
    check({tag, ".out_valid"}, W'(out_valid), W'(e_ov));
    check({tag, ".occupancy"}, W'(occupancy), W'(e_occ));
    if (e_ov) check({tag, ".out_data"}, out_data, e_od);
  endtask

  // Scoreboard (active during the random phase only)
  logic [W-1:0] exp_q[$];
  logic         sb_en = 1'b0;
  int           push_cnt = 0;
  int           pop_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (stall_prev) begin
        check("stall.out_valid", W'(out_valid), W'(1));
        check("stall.out_data", out_data, data_prev);
      end
      check("sb.occupancy", W'(occupancy), W'(exp_q.size()));
      check("sb.in_ready", W'(in_ready), W'(exp_q.size() < 2));
      check("sb.out_valid", W'(out_valid), W'(exp_q.size() > 0));
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb.pop_nonempty", W'(0), W'(1));
        end else begin
          check("sb.out_data", out_data, exp_q.pop_front());
        end
        pop_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        push_cnt++;
      end
    end
  end

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t vq[$];

  initial begin
    int cyc;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;

    // T1: reset held 3 cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("t1_reset", 1'b0, 1'b0, '0, 2'd0);
      check("t1_reset.out_data", out_data, '0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    check("t1_release.in_ready_before_edge", W'(in_ready), W'(0));
    step();
    check_outs("t1_release", 1'b1, 1'b0, '0, 2'd0);

    // T2 streaming, T3 backpressure, T4 push+pop in ONE; expected values are post-edge.
    for (int k = 1; k <= 8; k++)
      vq.push_back(vec_t'{1'b1, W'(k), 1'b1, 1'b1, 1'b1, W'(k), 2'd1});
    vq.push_back(vec_t'{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
    vq.push_back(vec_t'{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
    vq.push_back(vec_t'{1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 32'hA,  2'd1});
    vq.push_back(vec_t'{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2});
    vq.push_back(vec_t'{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2});
    vq.push_back(vec_t'{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2});
    vq.push_back(vec_t'{1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hB,  2'd1});
    vq.push_back(vec_t'{1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hC,  2'd1});
    vq.push_back(vec_t'{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hC,  2'd1});
    vq.push_back(vec_t'{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
    vq.push_back(vec_t'{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1});
    vq.push_back(vec_t'{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1});
    vq.push_back(vec_t'{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});

    for (int i = 0; i < vq.size(); i++) begin
      in_valid  = vq[i].iv;
      in_data   = vq[i].d;
      out_ready = vq[i].ordy;
      step();
      check_outs($sformatf("vec%0d", i), vq[i].e_ir, vq[i].e_ov, vq[i].e_od, vq[i].e_occ);
    end

    // T6: reset while full discards both beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_data = 32'h6;
    step();
    check_outs("t6_full", 1'b0, 1'b1, 32'h5, 2'd2);
    reset   = 1'b1;
    in_data = 32'h7;
    step();
    check_outs("t6_reset", 1'b0, 1'b0, '0, 2'd0);
    check("t6_reset.out_data", out_data, '0);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("t6_after", 1'b1, 1'b0, '0, 2'd0);
    end
    in_valid = 1'b1;
    in_data  = 32'h77;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check_outs("t6_new_beat", 1'b1, 1'b1, 32'h77, 2'd1);
    out_ready = 1'b1;
    step();
    check_outs("t6_drained", 1'b1, 1'b0, '0, 2'd0);

    // T5: random valid/ready at 50%, scoreboarded
    stall_prev = 1'b0;
    sb_en      = 1'b1;
    cyc        = 0;
    while (push_cnt < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check("t5.push_count", W'(push_cnt), W'(10000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    sb_en = 1'b0;
    check("t5.queue_empty", W'(exp_q.size()), W'(0));
    check("t5.pop_count", W'(pop_cnt), W'(push_cnt));
    check("t5.final_out_valid", W'(out_valid), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
